nexys_starship_rooms: RTL

Parametrised multi-room damage/repair controller for Nexys Starship. Tracks NUM_ROOMS rooms, each with its own INIT/WORKING/REPAIR state machine. Random break events arrive from the game's random source; the player repairs the room chosen by `sel` by entering the latched hex combo. The block adds per-room repair deadlines, an overload flag and status pulses for the top-level game controller and display logic.

---
 rtl/nexys_starship_rooms_if.sv | 32 +++
 rtl/nexys_starship_rooms.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_rooms_if.sv
// -----------------------------------------------------------------------------
// nexys_starship_rooms_if
// Player-side repair bus between the game front end and the room controller.
//   sel        : room targeted by a repair attempt
//   hex_combo  : combo entered by the player
//   submit     : one-cycle repair attempt pulse
//   sel_combo  : latched combo of room `sel` (0 when sel is out of range)
//   repair_ok  : registered pulse, correct combo accepted
//   repair_bad : registered pulse, wrong combo for a room under repair
// master = player / front end, slave = room controller.
// -----------------------------------------------------------------------------
interface nexys_starship_rooms_if #(
  parameter int SEL_W   = 2,
  parameter int COMBO_W = 4
) ();
  logic [SEL_W-1:0]   sel;
  logic [COMBO_W-1:0] hex_combo;
  logic               submit;
  logic [COMBO_W-1:0] sel_combo;
  logic               repair_ok;
  logic               repair_bad;

  modport master (
    output sel, hex_combo, submit,
    input  sel_combo, repair_ok, repair_bad
  );

  modport slave (
    input  sel, hex_combo, submit,
    output sel_combo, repair_ok, repair_bad
  );
endinterface

// File: rtl/nexys_starship_rooms.sv
// -----------------------------------------------------------------------------
// nexys_starship_rooms
// Multi-room damage/repair controller. Each room runs its own
// INIT -> WORKING -> REPAIR machine; a broken room carries a latched combo and
// a repair deadline counted in `tick` pulses.
// Ports:
//   Clk, Reset        : clock (rising edge), asynchronous active-low reset
//   play_flag         : game running, INIT rooms move to WORKING
//   gameover_ctrl     : all rooms back to INIT, clears expired
//   tick              : deadline timebase pulse
//   break_req         : per-room break request
//   break_combo       : combo latched into a room as it breaks
//   bus (slave)       : sel / hex_combo / submit in, sel_combo / repair_ok /
//                       repair_bad out
//   q_Init/q_Working/q_Repair : per-room one-hot state bits
//   broken            : per-room broken flag (same as q_Repair)
//   broken_count      : number of broken rooms
//   overload          : broken_count >= MAX_BROKEN
//   expired           : sticky, some room's deadline ran out
// -----------------------------------------------------------------------------
module nexys_starship_rooms #(
  parameter int NUM_ROOMS    = 4,
  parameter int COMBO_W      = 4,
  parameter int REPAIR_TICKS = 8,
  parameter int MAX_BROKEN   = 3,
  parameter int SEL_W        = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             play_flag,
  input  logic                             gameover_ctrl,
  input  logic                             tick,
  input  logic [NUM_ROOMS-1:0]             break_req,
  input  logic [COMBO_W-1:0]               break_combo,
  nexys_starship_rooms_if.slave            bus,
  output logic [NUM_ROOMS-1:0]             q_Init,
  output logic [NUM_ROOMS-1:0]             q_Working,
  output logic [NUM_ROOMS-1:0]             q_Repair,
  output logic [NUM_ROOMS-1:0]             broken,
  output logic [$clog2(NUM_ROOMS+1)-1:0]   broken_count,
  output logic                             overload,
  output logic                             expired
);

  localparam int CNT_W = $clog2(NUM_ROOMS + 1);
  localparam int TMR_W = $clog2(REPAIR_TICKS + 1);

  // One-hot encoding so the q_* outputs are direct flop bits.
  typedef enum logic [2:0] {
    ST_INIT    = 3'b001,
    ST_WORKING = 3'b010,
    ST_REPAIR  = 3'b100
  } room_state_e;

  room_state_e        state_r    [NUM_ROOMS];
  room_state_e        state_nx_s [NUM_ROOMS];
  logic [TMR_W-1:0]   timer_r    [NUM_ROOMS];
  logic [TMR_W-1:0]   timer_nx_s [NUM_ROOMS];
  logic [COMBO_W-1:0] combo_r    [NUM_ROOMS];
  logic [COMBO_W-1:0] combo_nx_s [NUM_ROOMS];
  logic [NUM_ROOMS-1:0] hit_s;

  logic ok_r, ok_nx_s;
  logic bad_r, bad_nx_s;
  logic expired_r, expired_nx_s;
  logic exp_ev_s;
  logic [CNT_W-1:0]   cnt_s;
  logic [COMBO_W-1:0] sel_combo_s;

  // Per-room decode of the state bits and of a submit aimed at that room.
  for (genvar g = 0; g < NUM_ROOMS; g++) begin : g_room
    assign q_Init[g]    = state_r[g][0];
    assign q_Working[g] = state_r[g][1];
    assign q_Repair[g]  = state_r[g][2];
    assign hit_s[g]     = bus.submit && (bus.sel == SEL_W'(g));
  end

  assign broken         = q_Repair;
  assign broken_count   = cnt_s;
  assign overload       = (cnt_s >= CNT_W'(MAX_BROKEN));
  assign bus.sel_combo  = sel_combo_s;
  assign bus.repair_ok  = ok_r;
  assign bus.repair_bad = bad_r;
  assign expired        = expired_r;

  // Popcount of broken rooms and mux of the selected room's combo.
  always_comb begin
    cnt_s       = {CNT_W{1'b0}};
    sel_combo_s = {COMBO_W{1'b0}};
    for (int i = 0; i < NUM_ROOMS; i++) begin
      cnt_s       = cnt_s + CNT_W'(q_Repair[i]);
      sel_combo_s = sel_combo_s |
                    (combo_r[i] & {COMBO_W{bus.sel == SEL_W'(i)}});
    end
  end

  // Next-state, timer, combo and pulse logic for every room.
  always_comb begin
    ok_nx_s  = 1'b0;
    bad_nx_s = 1'b0;
    exp_ev_s = 1'b0;
    for (int i = 0; i < NUM_ROOMS; i++) begin
      state_nx_s[i] = state_r[i];
      timer_nx_s[i] = timer_r[i];
      combo_nx_s[i] = combo_r[i];
      if (gameover_ctrl) begin
        state_nx_s[i] = ST_INIT;
        timer_nx_s[i] = {TMR_W{1'b0}};
      end else begin
        case (state_r[i])
          ST_INIT: begin
            timer_nx_s[i] = {TMR_W{1'b0}};
            if (play_flag) begin
              state_nx_s[i] = ST_WORKING;
            end else begin
              state_nx_s[i] = ST_INIT;
            end
          end
          ST_WORKING: begin
            if (break_req[i]) begin
              state_nx_s[i] = ST_REPAIR;
              combo_nx_s[i] = break_combo;
              timer_nx_s[i] = TMR_W'(REPAIR_TICKS);
            end else begin
              state_nx_s[i] = ST_WORKING;
            end
          end
          ST_REPAIR: begin
            // A submit aimed at this room takes precedence over the tick,
            // so a correct repair on the last tick never flags expiry.
            if (hit_s[i]) begin
              if (bus.hex_combo == combo_r[i]) begin
                state_nx_s[i] = ST_WORKING;
                ok_nx_s       = 1'b1;
              end else begin
                bad_nx_s      = 1'b1;
              end
            end else if (tick && (timer_r[i] != {TMR_W{1'b0}})) begin
              timer_nx_s[i] = timer_r[i] - TMR_W'(1);
              if (timer_r[i] == TMR_W'(1)) begin
                exp_ev_s = 1'b1;
              end else begin
                exp_ev_s = exp_ev_s;
              end
            end else begin
              timer_nx_s[i] = timer_r[i];
            end
          end
          default: begin
            state_nx_s[i] = ST_INIT;
            timer_nx_s[i] = {TMR_W{1'b0}};
          end
        endcase
      end
    end
    if (gameover_ctrl) begin
      expired_nx_s = 1'b0;
    end else begin
      expired_nx_s = expired_r | exp_ev_s;
    end
  end

  // State, timer, combo and status registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        state_r[i] <= ST_INIT;
        timer_r[i] <= {TMR_W{1'b0}};
        combo_r[i] <= {COMBO_W{1'b0}};
      end
      ok_r      <= 1'b0;
      bad_r     <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        state_r[i] <= state_nx_s[i];
        timer_r[i] <= timer_nx_s[i];
        combo_r[i] <= combo_nx_s[i];
      end
      ok_r      <= ok_nx_s;
      bad_r     <= bad_nx_s;
      expired_r <= expired_nx_s;
    end
  end

endmodule
